// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table scanner.
// Holds the FSM state encoding, table geometry and the settle-time default.
package tt_pkg;

    localparam int IDX_W              = 3;
    localparam int TABLE_W            = 8;
    localparam int CNT_W              = 4;
    localparam int SETTLE_CYCLES_DEF  = 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TABLE_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Lowest bit position where the two tables disagree; 0 when they are equal.
    function automatic logic [IDX_W-1:0] lowest_diff(input logic [TABLE_W-1:0] x,
                                                     input logic [TABLE_W-1:0] y);
        logic [IDX_W-1:0] pos;
        pos = '0;
        for (int i = TABLE_W - 1; i >= 0; i--) begin
            if (x[i] != y[i]) pos = IDX_W'(i);
        end
        return pos;
    endfunction

endpackage

// File: rtl/tt_scanner_settle_timer.sv
// Settle timer: counts cycles spent waiting for the function under test.
// tc is high on the last wait cycle so the FSM can move to sampling.
module settle_timer
    import tt_pkg::*;
#(
    parameter int TERMINAL = SETTLE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic tc
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == CNT_W'(TERMINAL - 1));

endmodule

// File: rtl/tt_scanner.sv
// Truth-table scanner: walks a 3-input function through all 8 patterns,
// records its response and compares the result with a latched golden table.
module tt_scanner
    import tt_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [TABLE_W-1:0] expected,
    output logic               a,
    output logic               b,
    output logic               c,
    input  logic               e_in,
    output logic               busy,
    output logic               done,
    output logic [TABLE_W-1:0] table_out,
    output logic               match,
    output logic [IDX_W-1:0]   first_miss,
    output state_t             state
);

    state_t             state_q;
    logic [IDX_W-1:0]   idx;
    logic [TABLE_W-1:0] expected_q;
    logic [TABLE_W-1:0] next_table;
    logic               timer_load;
    logic               timer_en;
    logic               timer_tc;

    // Table as it will look once the current pattern's response is written.
    always_comb begin
        next_table      = table_out;
        next_table[idx] = e_in;
    end

    assign timer_load = ((state_q == ST_IDLE) && start) ||
                        ((state_q == ST_SAMPLE) && (idx != LAST_IDX));
    assign timer_en   = (state_q == ST_WAIT);

    settle_timer #(
        .TERMINAL (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .enable (timer_en),
        .tc     (timer_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx        <= '0;
            expected_q <= '0;
            table_out  <= '0;
            match      <= 1'b0;
            first_miss <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        idx        <= '0;
                        expected_q <= expected;
                        table_out  <= '0;
                        match      <= 1'b0;
                        first_miss <= '0;
                        state_q    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (timer_tc) state_q <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    table_out <= next_table;
                    // Verdict is formed here so it is already valid while done is high.
                    if (idx == LAST_IDX) begin
                        match      <= (next_table == expected_q);
                        first_miss <= lowest_diff(next_table, expected_q);
                        state_q    <= ST_DONE;
                    end else begin
                        idx     <= idx + 1'b1;
                        state_q <= ST_WAIT;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // The pattern index itself drives the stimulus, so it only moves on SAMPLE->WAIT.
    assign {a, b, c} = idx;
    assign busy      = (state_q == ST_WAIT) || (state_q == ST_SAMPLE);
    assign done      = (state_q == ST_DONE);
    assign state     = state_q;

endmodule

// File: tb/tb_tt_scanner.sv
// Self-checking bench for tt_scanner: two instances (settle 2 and settle 1),
// randomized scans checked against a reference model through a scoreboard.
module tb_tt_scanner;

    localparam int W = 44;  // {done_edge[31:0], table[7:0], match, first_miss[2:0]}

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance 0: default settle time, function under test from a table.
    logic               st0 = 1'b0;
    logic [7:0]         expected0 = 8'h00;
    logic [7:0]         fut = 8'h00;
    logic               a0, b0, c0, e_in0, busy0, done0, match0;
    logic [7:0]         table0;
    logic [2:0]         miss0;
    tt_pkg::state_t     state0;

    // Instance 1: settle time 1, response tied high.
    logic               st1 = 1'b0;
    logic [7:0]         expected1 = 8'h00;
    logic               a1, b1, c1, busy1, done1, match1;
    logic [7:0]         table1;
    logic [2:0]         miss1;
    tt_pkg::state_t     state1;

    logic [W-1:0] exp0_q[$];
    logic [W-1:0] exp1_q[$];

    assign e_in0 = fut[{a0, b0, c0}];

    tt_scanner #(.SETTLE_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .start(st0), .expected(expected0),
        .a(a0), .b(b0), .c(c0), .e_in(e_in0),
        .busy(busy0), .done(done0), .table_out(table0),
        .match(match0), .first_miss(miss0), .state(state0)
    );

    tt_scanner #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(st1), .expected(expected1),
        .a(a1), .b(b1), .c(c1), .e_in(1'b1),
        .busy(busy1), .done(done1), .table_out(table1),
        .match(match1), .first_miss(miss1), .state(state1)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference: e = (~a & ~b) | ~c evaluated per pattern index.
    function automatic logic [7:0] formula_table();
        logic [7:0] t;
        for (int i = 0; i < 8; i++) begin
            int av, bv, cv;
            av = (i / 4) % 2;
            bv = (i / 2) % 2;
            cv = i % 2;
            t[i] = ((av == 0) && (bv == 0)) || (cv == 0);
        end
        return t;
    endfunction

    function automatic logic [2:0] ref_first_miss(input logic [7:0] t, input logic [7:0] x);
        for (int i = 0; i < 8; i++) begin
            if (t[i] != x[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    // Scan accepted at edge k shows done during the cycle after edge k + 8*(s+1).
    function automatic logic [W-1:0] ref_entry(input int k, input int s,
                                               input logic [7:0] t, input logic [7:0] x);
        return {32'(k + 8 * (s + 1)), t, (t == x), ref_first_miss(t, x)};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the caller at the negedge right after the accepting edge.
    task automatic issue0(input logic [7:0] x);
        int k;
        @(negedge clk);
        st0 = 1'b1;
        expected0 = x;
        k = cyc + 1;
        exp0_q.push_back(ref_entry(k, 2, fut, x));
        @(negedge clk);
        st0 = 1'b0;
    endtask

    task automatic issue1(input logic [7:0] x);
        int k;
        @(negedge clk);
        st1 = 1'b1;
        expected1 = x;
        k = cyc + 1;
        exp1_q.push_back(ref_entry(k, 1, 8'hFF, x));
        @(negedge clk);
        st1 = 1'b0;
    endtask

    // Monitors: pop and compare whenever a done pulse is presented.
    always @(negedge clk) begin
        if (!rst && done0) begin
            if (exp0_q.size() == 0) begin
                chk("dut0_unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [W-1:0] e;
                e = exp0_q.pop_front();
                chk("dut0_done_edge", 32'(cyc), e[43:12]);
                chk("dut0_table", 32'(table0), 32'(e[11:4]));
                chk("dut0_match", 32'(match0), 32'(e[3]));
                chk("dut0_first_miss", 32'(miss0), 32'(e[2:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done1) begin
            if (exp1_q.size() == 0) begin
                chk("dut1_unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [W-1:0] e;
                e = exp1_q.pop_front();
                chk("dut1_done_edge", 32'(cyc), e[43:12]);
                chk("dut1_table", 32'(table1), 32'(e[11:4]));
                chk("dut1_match", 32'(match1), 32'(e[3]));
                chk("dut1_first_miss", 32'(miss1), 32'(e[2:0]));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_state0"}, 32'(state0), 32'(tt_pkg::ST_IDLE));
        chk({tag, "_abc0"}, 32'({a0, b0, c0}), 32'd0);
        chk({tag, "_busy0"}, 32'(busy0), 32'd0);
        chk({tag, "_done0"}, 32'(done0), 32'd0);
        chk({tag, "_table0"}, 32'(table0), 32'd0);
        chk({tag, "_match0"}, 32'(match0), 32'd0);
        chk({tag, "_miss0"}, 32'(miss0), 32'd0);
    endtask

    initial begin
        logic [7:0] f57;
        int k;
        int w;
        f57 = formula_table();
        fut = f57;

        // Reset with start held high: start must be ignored during reset.
        st0 = 1'b1;
        st1 = 1'b1;
        idle(3);
        check_all_zero("reset");
        chk("reset_state1", 32'(state1), 32'(tt_pkg::ST_IDLE));
        chk("reset_abc1", 32'({a1, b1, c1}), 32'd0);
        chk("reset_busy1", 32'(busy1), 32'd0);
        st0 = 1'b0;
        st1 = 1'b0;
        rst = 1'b0;
        idle(2);

        // Matching scan, with stimulus sequence and busy window watched.
        issue0(8'h57);
        for (int j = 0; j < 24; j++) begin
            chk("abc_sequence", 32'({a0, b0, c0}), 32'(j / 3));
            chk("busy_window", 32'(busy0), 32'd1);
            @(negedge clk);
        end
        chk("busy_after_last_sample", 32'(busy0), 32'd0);
        idle(2);

        // Mismatching golden table.
        issue0(8'h5F);
        idle(26);
        chk("hold_table_idle", 32'(table0), 32'h57);
        chk("hold_miss_idle", 32'(miss0), 32'd3);

        // Reset during pattern 4 wait.
        issue0(8'h57);
        idle(12);
        chk("abc_before_reset", 32'({a0, b0, c0}), 32'd4);
        rst = 1'b1;
        exp0_q.delete();
        @(negedge clk);
        check_all_zero("midscan_reset");
        rst = 1'b0;
        idle(1);
        issue0(8'h57);
        idle(26);

        // Start pulse and golden change while busy: no restart, original golden used.
        issue0(8'h57);
        idle(5);
        st0 = 1'b1;
        expected0 = 8'h00;
        @(negedge clk);
        st0 = 1'b0;
        idle(20);

        // Start held through DONE: a second scan begins two edges after done.
        @(negedge clk);
        st0 = 1'b1;
        expected0 = 8'h57;
        k = cyc + 1;
        exp0_q.push_back(ref_entry(k, 2, fut, 8'h57));
        exp0_q.push_back(ref_entry(k + 26, 2, fut, 8'h57));
        idle(27);
        st0 = 1'b0;
        idle(26);

        // Randomized functions, golden tables and mid-scan disturbances.
        for (int n = 0; n < 24; n++) begin
            logic [7:0] x;
            fut = 8'($urandom);
            x = ($urandom_range(0, 2) == 0) ? fut : 8'($urandom);
            issue0(x);
            if ($urandom_range(0, 1) == 1) begin
                w = $urandom_range(1, 20);
                idle(w);
                st0 = 1'b1;
                expected0 = 8'($urandom);
                @(negedge clk);
                st0 = 1'b0;
                idle(25 - w);
            end else begin
                idle(26);
            end
            idle($urandom_range(0, 3));
        end

        // Short settle time, response tied high.
        issue1(8'hFF);
        idle(18);
        issue1(8'hFE);
        idle(18);
        issue1(8'($urandom));
        idle(18);

        for (int t = 0; t < 50 && (exp0_q.size() + exp1_q.size()) > 0; t++) begin
            @(negedge clk);
        end
        chk("dut0_queue_drained", 32'(exp0_q.size()), 32'd0);
        chk("dut1_queue_drained", 32'(exp1_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_scanner.md
TT_SCANNER -- requirements
Module: tt_scanner

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, number of wait cycles between driving an input pattern and sampling the response; legal range 1..15.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request one full truth-table scan; sampled only in IDLE.
REQ-005 expected  input  8  golden truth table, bit i = required response for pattern i; captured on accepted start.
REQ-006 a, b, c  output  1 each  stimulus to the 3-input function under test; {a,b,c} = pattern index, a is MSB.
REQ-007 e_in  input  1  response of the function under test.
REQ-008 busy  output  1  high from the cycle after an accepted start through the last SAMPLE cycle.
REQ-009 done  output  1  single-cycle pulse when a scan completes.
REQ-010 table_out  output  8  captured truth table, bit i = e_in sampled for pattern i.
REQ-011 match  output  1  table_out equals captured expected; valid from done, held until next start.
REQ-012 first_miss  output  3  lowest index where table_out and expected differ; 0 when match.

Function
REQ-013 States: IDLE, WAIT, SAMPLE, DONE.
REQ-014 IDLE with start=1: idx<=0, {a,b,c}<=3'b000, settle count<=0, table_out<=0, match<=0, first_miss<=0, expected latched, next WAIT.
REQ-015 WAIT: count increments each cycle; after SETTLE_CYCLES cycles in WAIT, next SAMPLE.
REQ-016 SAMPLE: table_out[idx]<=e_in; if idx==7 next DONE, else idx<=idx+1, {a,b,c}<=idx+1, count<=0, next WAIT.
REQ-017 DONE: done=1 for exactly this cycle, match and first_miss updated from final table, next IDLE.
REQ-018 Cost per pattern is SETTLE_CYCLES+1 cycles; start accepted at edge k gives done high in cycle k+1+8*(SETTLE_CYCLES+1) (k+25 at default).
REQ-019 start while not in IDLE is ignored; no queueing; start held high through DONE starts a new scan from IDLE on the following edge.
REQ-020 {a,b,c} stable for the whole WAIT and SAMPLE of each pattern; change only on SAMPLE->WAIT transition or on accepted start.
REQ-021 expected changes after start do not affect match or first_miss.
REQ-022 idx is 3 bits; increment never wraps (DONE taken at idx==7).
REQ-023 table_out, match, first_miss hold their values in IDLE until the next accepted start.

Reset
REQ-024 rst=1 at any edge, including mid-scan: state<=IDLE, idx, count, {a,b,c}, table_out, match, first_miss, busy, done all <=0.
REQ-025 start asserted in the same cycle as rst is ignored.

Structure
REQ-026 Shared package tt_pkg holds the state enum, IDX_W=3, TABLE_W=8 and the SETTLE_CYCLES default.
REQ-027 One sub-module settle_timer (load, enable, terminal-count output) implements the WAIT counter; remaining logic lives in tt_scanner.

Verification
REQ-028 Function under test e=(~a&~b)|~c, SETTLE_CYCLES=2, expected=8'h57, pulse start -> done at start edge+25, table_out=8'h57, match=1, first_miss=0.
REQ-029 Same function, expected=8'h5F -> table_out=8'h57, match=0, first_miss=3.
REQ-030 Monitor {a,b,c} during scan -> sequence 0..7, each value held exactly 3 cycles, busy high 24 cycles.
REQ-031 Assert rst during pattern 4 WAIT -> next cycle all outputs 0, state IDLE; subsequent start yields full scan with table_out=8'h57.
REQ-032 Pulse start again while busy, and change expected mid-scan -> no restart, done timing unchanged, match computed against originally latched value.
REQ-033 SETTLE_CYCLES=1, e_in tied 1, expected=8'hFF -> done at start edge+17, table_out=8'hFF, match=1.
